pbus_mem_arbiter: RTL and testbench



---
 rtl/pbus_mem_arbiter_pkg.sv | 23 ++
 rtl/pbus_sat_counter.sv | 22 ++
 rtl/pbus_mem_arbiter.sv | 119 +++++++++++
 tb/tb_pbus_mem_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pbus_mem_arbiter_pkg.sv
// Shared definitions for the PBus benchmark memory arbiter: reserved address
// map, control register bit positions, kernel handshake states.
package pbus_mem_arbiter_pkg;

    localparam int STALL_W   = 16;
    localparam int RUN_BIT   = 0;
    localparam int KDONE_BIT = 1;

    typedef enum logic {
        K_IDLE = 1'b0,
        K_ACK  = 1'b1
    } kstate_t;

    // The two topmost addresses of the space are the control/status window.
    function automatic logic [31:0] ctrl_addr(input int aw);
        return (32'h1 << aw) - 32'h1;
    endfunction

    function automatic logic [31:0] stat_addr(input int aw);
        return ctrl_addr(aw) - 32'h1;
    endfunction

endpackage

// File: rtl/pbus_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module pbus_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pbus_mem_arbiter.sv
// Single-port benchmark RAM shared between PBus host strobes (always win) and
// a req/ack kernel port, plus a host-visible Run/KDone control and stall counter.
module pbus_mem_arbiter
    import pbus_mem_arbiter_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          Clk,
    input  logic          PBusResetN,
    input  logic          RD,
    input  logic          WR,
    input  logic [AW-1:0] HAddr,
    input  logic [DW-1:0] HWData,
    output logic [DW-1:0] HRData,
    input  logic          KReq,
    input  logic          KWe,
    input  logic [AW-1:0] KAddr,
    input  logic [DW-1:0] KWData,
    output logic          KAck,
    output logic [DW-1:0] KRData,
    input  logic          KDone,
    output logic          Run,
    output logic          MemEn,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData
);

    localparam logic [AW-1:0] CTRL_ADDR = AW'(ctrl_addr(AW));
    localparam logic [AW-1:0] STAT_ADDR = AW'(stat_addr(AW));

    kstate_t             state, state_nxt;
    logic                host, host_rd, hit_ctrl, hit_stat, hit_rsv;
    logic                grant, stall_inc, stat_clr;
    logic                run, kwe_q, rd_pend, rsv_q;
    logic [DW-1:0]       krdata_q, rsv_val_q, ctrl_word, stat_word;
    logic [STALL_W-1:0]  stall_cnt;

    assign host     = RD | WR;
    assign host_rd  = RD & ~WR;
    assign hit_ctrl = (HAddr == CTRL_ADDR);
    assign hit_stat = (HAddr == STAT_ADDR);
    assign hit_rsv  = hit_ctrl | hit_stat;

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            K_IDLE: begin
                if (KReq && run && !host) begin
                    grant     = 1'b1;
                    state_nxt = K_ACK;
                end
            end
            K_ACK:   state_nxt = K_IDLE;
            default: state_nxt = K_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge PBusResetN) begin
        if (!PBusResetN) state <= K_IDLE;
        else             state <= state_nxt;
    end

    assign stall_inc = (state == K_IDLE) && KReq && !grant;
    assign stat_clr  = WR && hit_stat;

    pbus_sat_counter #(.W(STALL_W)) u_stall (
        .clk   (Clk),
        .rst_n (PBusResetN),
        .clr   (stat_clr),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    // RAM port mux; gating with reset keeps the RAM quiet while held in reset.
    assign MemEn    = PBusResetN && ((host && !hit_rsv) || grant);
    assign MemWe    = MemEn && (host ? WR : KWe);
    assign MemAddr  = host ? HAddr  : KAddr;
    assign MemWData = host ? HWData : KWData;

    always_comb begin
        ctrl_word            = '0;
        ctrl_word[RUN_BIT]   = run;
        ctrl_word[KDONE_BIT] = KDone;
    end
    assign stat_word = DW'(stall_cnt);

    // Reserved-space reads snapshot the status in the RD cycle so they line up
    // with the RAM read data that appears one cycle later.
    always_ff @(posedge Clk or negedge PBusResetN) begin
        if (!PBusResetN) begin
            run       <= 1'b0;
            kwe_q     <= 1'b0;
            krdata_q  <= '0;
            rd_pend   <= 1'b0;
            rsv_q     <= 1'b0;
            rsv_val_q <= '0;
            HRData    <= '0;
        end else begin
            if (WR && hit_ctrl) run <= HWData[RUN_BIT];
            if (grant) kwe_q <= KWe;
            if ((state == K_ACK) && !kwe_q) krdata_q <= MemRData;
            rd_pend <= host_rd;
            if (host_rd) begin
                rsv_q     <= hit_rsv;
                rsv_val_q <= hit_ctrl ? ctrl_word : stat_word;
            end
            if (rd_pend) HRData <= rsv_q ? rsv_val_q : MemRData;
        end
    end

    assign Run    = run;
    assign KAck   = (state == K_ACK);
    assign KRData = (KAck && !kwe_q) ? MemRData : krdata_q;

endmodule

// File: tb/tb_pbus_mem_arbiter.sv
// Randomized + directed bench for pbus_mem_arbiter against a transaction-level
// model of the memory, control register, stall counter and kernel handshake.
module tb_pbus_mem_arbiter;

    localparam logic [7:0] CTRL = 8'hFF;
    localparam logic [7:0] STAT = 8'hFE;

    logic        Clk = 1'b0;
    logic        PBusResetN;
    logic        RD, WR, KReq, KWe, KDone, KAck, Run, MemEn, MemWe;
    logic [7:0]  HAddr, KAddr, MemAddr;
    logic [31:0] HWData, HRData, KWData, KRData, MemWData;
    logic [31:0] MemRData = '0;
    logic [31:0] ram [256] = '{default: 32'h0};

    always #5 Clk = ~Clk;

    pbus_mem_arbiter #(.AW(8), .DW(32)) dut (
        .Clk(Clk), .PBusResetN(PBusResetN), .RD(RD), .WR(WR), .HAddr(HAddr),
        .HWData(HWData), .HRData(HRData), .KReq(KReq), .KWe(KWe), .KAddr(KAddr),
        .KWData(KWData), .KAck(KAck), .KRData(KRData), .KDone(KDone), .Run(Run),
        .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemRData(MemRData)
    );

    always @(posedge Clk) begin
        if (MemEn) begin
            if (MemWe) ram[MemAddr] <= MemWData;
            else       MemRData     <= ram[MemAddr];
        end
    end

    // reference model state
    logic [31:0] mm [256];
    bit          m_run, m_ack, m_ack_rd, hr_pend, last_ack;
    int          m_stall;
    logic [31:0] m_ack_data, m_krdata, m_hr, hr_val;
    int          n_chk, n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_stall = 0; m_ack = 0; m_ack_rd = 0;
        m_krdata = '0; m_hr = '0; hr_pend = 0;
    endtask

    // One clock cycle: drive host strobe (kernel signals come from KReq/KWe/...),
    // compare mid-cycle, then advance the model across the edge.
    task automatic step(input bit rd, input bit wr, input logic [7:0] ha, input logic [31:0] hd);
        bit host, rsv, grant, en;
        RD = rd; WR = wr; HAddr = ha; HWData = hd;
        @(negedge Clk);
        host  = rd | wr;
        rsv   = (ha == CTRL) || (ha == STAT);
        grant = !m_ack && KReq && m_run && !host;
        en    = (host && !rsv) || grant;
        chk("kack",   {31'b0, KAck}, {31'b0, m_ack});
        chk("run",    {31'b0, Run},  {31'b0, m_run});
        chk("hrdata", HRData, m_hr);
        chk("krdata", KRData, (m_ack && m_ack_rd) ? m_ack_data : m_krdata);
        chk("memen",  {31'b0, MemEn}, {31'b0, en});
        if (en) begin
            chk("memwe",   {31'b0, MemWe}, {31'b0, (host ? wr : KWe)});
            chk("memaddr", {24'b0, MemAddr}, {24'b0, (host ? ha : KAddr)});
            if (MemWe) chk("memwdata", MemWData, host ? hd : KWData);
        end
        last_ack = m_ack;
        if (hr_pend) m_hr = hr_val;
        hr_pend = rd && !wr;
        if (hr_pend)
            hr_val = (ha == CTRL) ? {30'b0, KDone, m_run} :
                     (ha == STAT) ? m_stall : mm[ha];
        if (m_ack) begin
            if (m_ack_rd) m_krdata = m_ack_data;
            m_ack = 0;
        end else if (grant) begin
            m_ack = 1; m_ack_rd = !KWe;
            if (KWe) mm[KAddr] = KWData;
            else     m_ack_data = mm[KAddr];
        end else if (KReq) begin
            m_stall = (m_stall >= 65535) ? 65535 : m_stall + 1;
        end
        if (wr) begin
            if (ha == CTRL)      m_run = hd[0];
            else if (ha == STAT) m_stall = 0;
            else                 mm[ha] = hd;
        end
        @(posedge Clk); #1;
    endtask

    task automatic idle();
        step(0, 0, 8'h00, 32'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        bit prev_host;
        int r;
        n_chk = 0; n_fail = 0; prev_host = 0;
        for (int i = 0; i < 256; i++) mm[i] = '0;
        model_reset();
        PBusResetN = 0; RD = 1; WR = 0; HAddr = 8'h10; HWData = '0;
        KReq = 0; KWe = 0; KAddr = '0; KWData = '0; KDone = 0;
        #12;
        chk("rst_kack",   {31'b0, KAck}, 32'h0);
        chk("rst_run",    {31'b0, Run},  32'h0);
        chk("rst_hrdata", HRData, 32'h0);
        chk("rst_krdata", KRData, 32'h0);
        chk("rst_memen",  {31'b0, MemEn}, 32'h0);
        RD = 0;
        @(negedge Clk); PBusResetN = 1;
        @(posedge Clk); #1;

        // host write then read back
        step(0, 1, 8'h10, 32'hCAFEF00D);
        idle();
        step(1, 0, 8'h10, 32'h0);
        idle();
        chk("host_rd", HRData, 32'hCAFEF00D);

        // Run=0: kernel stalls, then clear the counter
        KReq = 1; KWe = 0; KAddr = 8'h10;
        repeat (5) idle();
        KReq = 0;
        step(1, 0, STAT, 32'h0); idle();
        chk("stall5", HRData, 32'd5);
        step(0, 1, STAT, 32'h0); idle();
        step(1, 0, STAT, 32'h0); idle();
        chk("stall_clr", HRData, 32'd0);

        // Run=1: kernel write then read 0x20
        step(0, 1, CTRL, 32'h1); idle();
        KReq = 1; KWe = 1; KAddr = 8'h20; KWData = 32'h1234;
        idle();
        chk("kwr_ack", {31'b0, KAck}, 32'h1);
        idle();
        KWe = 0;
        idle();
        chk("krd_ack", {31'b0, KAck}, 32'h1);
        chk("krd_data", KRData, 32'h1234);
        idle();
        KReq = 0; KDone = 1;
        step(1, 0, CTRL, 32'h0); idle();
        chk("ctrl_rd", HRData, 32'h3);

        // host read collides with kernel request
        KReq = 1; KWe = 0; KAddr = 8'h10;
        step(1, 0, 8'h20, 32'h0);
        chk("coll_noack", {31'b0, KAck}, 32'h0);
        idle();
        chk("coll_ack",  {31'b0, KAck}, 32'h1);
        chk("coll_kdat", KRData, 32'hCAFEF00D);
        chk("coll_hdat", HRData, 32'h1234);
        idle();
        KReq = 0;
        step(1, 0, STAT, 32'h0); idle();
        chk("coll_stall", HRData, 32'd1);

        // saturation with Run=0
        step(0, 1, CTRL, 32'h0);
        KReq = 1;
        repeat (65540) @(posedge Clk);
        #1;
        KReq = 0;
        m_stall = (m_stall + 65540 > 65535) ? 65535 : m_stall + 65540;
        step(1, 0, STAT, 32'h0); idle();
        chk("stall_sat", HRData, 32'h0000FFFF);

        // async reset while in K_ACK
        step(0, 1, CTRL, 32'h1);
        KReq = 1; KWe = 0; KAddr = 8'h20;
        idle();
        RD = 1; HAddr = 8'h10;
        #2 PBusResetN = 0;
        #1;
        chk("arst_kack",  {31'b0, KAck}, 32'h0);
        chk("arst_run",   {31'b0, Run},  32'h0);
        chk("arst_memen", {31'b0, MemEn}, 32'h0);
        RD = 0; KReq = 0;
        @(negedge Clk); PBusResetN = 1;
        model_reset();
        @(posedge Clk); #1;
        idle(); idle();
        chk("no_spur_ack", {31'b0, KAck}, 32'h0);

        // randomized traffic
        step(0, 1, CTRL, 32'h1);
        for (int c = 0; c < 2000; c++) begin
            bit rd, wr;
            logic [7:0]  ha;
            logic [31:0] hd;
            rd = 0; wr = 0; ha = '0; hd = $urandom;
            if (!prev_host && $urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 9);
                ha = (r == 8) ? STAT : (r == 9) ? CTRL : 8'($urandom_range(0, 15));
                r = $urandom_range(0, 5);
                rd = (r != 0); wr = (r <= 2);
                if (ha == CTRL) hd[0] = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 15) == 0) KDone = ~KDone;
            step(rd, wr, ha, hd);
            prev_host = rd | wr;
            if (last_ack) begin
                KReq = 0;
            end else if (!KReq && $urandom_range(0, 2) == 0) begin
                KReq = 1; KWe = $urandom_range(0, 1);
                KAddr = ($urandom_range(0, 15) == 0) ? CTRL : 8'($urandom_range(0, 15));
                KWData = $urandom;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
